alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal 8..64).
REQ-002 SHALL have parameter CNTW, default 6, iteration-counter width (2^CNTW > WIDTH).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  op request, sampled when busy=0.
REQ-006 SHALL have port gin  input  4  ALU control line selecting operation.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port sum  output  WIDTH  registered result.
REQ-010 SHALL have port zout  output  1  registered, 1 when sum is all zeros.
REQ-011 SHALL have port dz  output  1  divide-by-zero flag for last op.
REQ-012 SHALL have port busy  output  1  multi-cycle op in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse, sum/zout/dz valid.

Function
REQ-014 SHALL decode gin: 0010 ADD, 0110 SUB (a+~b+1), 0111 SLT signed, 0011 SLTU unsigned, 0000 AND, 0001 OR, 1100 NOR, 1000 MUL, 1001 DIVU.
REQ-015 SHALL compute ADD/SUB modulo 2^WIDTH, carry discarded.
REQ-016 SHALL give SLT = 1 iff signed a < signed b, using true overflow-corrected comparison, not difference sign bit alone; SLT/SLTU result zero-extended to WIDTH.
REQ-017 SHALL complete single-cycle ops (all but MUL/DIVU) with done=1 on the cycle after start, busy never asserted.
REQ-018 SHALL implement MUL as unsigned shift-add, one bit per cycle, sum = low WIDTH bits of a*b.
REQ-019 SHALL implement DIVU as restoring division, one bit per cycle, sum = floor(a/b).
REQ-020 SHALL, for MUL/DIVU, assert busy from cycle after start for WIDTH cycles, then done on cycle WIDTH+1 after start, busy low that cycle.
REQ-021 SHALL use FSM states IDLE -> (MUL|DIV) -> FIN -> IDLE; single-cycle ops go IDLE -> FIN -> IDLE.
REQ-022 SHALL latch a, b, gin on start; operand changes afterwards have no effect.
REQ-023 SHALL ignore start while busy=1; start in FIN cycle SHALL be accepted (back-to-back).
REQ-024 SHALL, on DIVU with b=0, skip iteration, go to FIN next cycle, set sum all ones, dz=1.
REQ-025 SHALL clear dz on every completed op other than DIVU by zero.
REQ-026 SHALL, for undefined gin, complete in one cycle with sum=0, zout=1.
REQ-027 SHALL hold sum, zout, dz stable between done pulses.

Reset
REQ-028 SHALL on rst_n=0 immediately force state IDLE, sum=0, zout=1, dz=0, busy=0, done=0, counter=0.
REQ-029 SHALL abort any in-flight MUL/DIVU on reset with no done pulse afterward.
REQ-030 SHALL accept start on first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL place gin opcode constants and FSM state encodings in shared package alu_pkg.
REQ-032 SHALL place iterative MUL/DIVU datapath (partial product/remainder registers, counter) in sub-module alu_iter; single-cycle ops and control stay in alu_seq.

Verification
REQ-033 SHALL test ADD 0xFFFFFFFF+1 (WIDTH=32) -> sum=0, zout=1, done one cycle after start.
REQ-034 SHALL test SLT a=0x80000000, b=1 -> sum=1; SLTU same operands -> sum=0; SLT a=0x7FFFFFFF, b=0x80000000 -> sum=0.
REQ-035 SHALL test MUL a=12345, b=6789 -> sum=83810205, busy 32 cycles, done on cycle 33; start pulsed mid-op ignored.
REQ-036 SHALL test DIVU a=100, b=7 -> sum=14, dz=0; DIVU a=5, b=0 -> sum=0xFFFFFFFF, dz=1, done in 2 cycles.
REQ-037 SHALL test rst_n low at cycle 10 of MUL -> outputs at reset values, no done; next ADD 3+4 -> sum=7.
REQ-038 SHALL test WIDTH=8 MUL 0x10*0x10 -> sum=0x00, zout=1, done on cycle 9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIN  = 2'b11
    } state_t;

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath shared by unsigned shift-add multiply and restoring divide.
// One bit per step; result is the value the registers take after the current step.
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    // hi: product accumulator / remainder, lo: multiplier / quotient, m: multiplicand / divisor
    logic [WIDTH-1:0] hi, lo, m;
    logic [CNTW-1:0]  count;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] hi_next, lo_next, m_next;

    always_comb begin
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, m};
        if (div) begin
            // A borrow out of the trial subtraction means restore the shifted remainder
            if (diff[WIDTH]) begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end else begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end
            m_next = m;
        end else begin
            hi_next = lo[0] ? hi + m : hi;
            lo_next = lo >> 1;
            m_next  = m << 1;
        end
    end

    assign result = div ? lo_next : hi_next;
    assign last   = (count == CNTW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            m     <= '0;
            count <= '0;
        end else if (load) begin
            hi    <= '0;
            lo    <= div ? a : b;
            m     <= div ? b : a;
            count <= '0;
        end else if (step) begin
            hi    <= hi_next;
            lo    <= lo_next;
            m     <= m_next;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus multi-cycle MUL and DIVU,
// with registered result, zero flag and divide-by-zero flag.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       gin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             zout,
    output logic             dz,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic             div_zero;
    logic             accept, iter_load, iter_step, iter_div, iter_last;
    logic [WIDTH-1:0] iter_result, quick_result, diff;

    // Start is honoured whenever no multi-cycle op is running, including the FIN cycle
    assign accept    = start && (state == ST_IDLE || state == ST_FIN);
    assign iter_load = accept && (gin == OP_MUL || gin == OP_DIVU);
    assign iter_step = (state == ST_MUL) || (state == ST_DIV && !div_zero);
    assign iter_div  = iter_load ? (gin == OP_DIVU) : (state == ST_DIV);
    assign diff      = a + ~b + 1'b1;

    always_comb begin
        quick_result = '0;
        case (gin)
            OP_ADD:  quick_result = a + b;
            OP_SUB:  quick_result = diff;
            // Differing signs decide directly; otherwise the difference cannot overflow
            OP_SLT:  quick_result = WIDTH'((a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1]);
            OP_SLTU: quick_result = WIDTH'(a < b);
            OP_AND:  quick_result = a & b;
            OP_OR:   quick_result = a | b;
            OP_NOR:  quick_result = ~(a | b);
            default: quick_result = '0;
        endcase
    end

    alu_iter #(.WIDTH(WIDTH), .CNTW(CNTW)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (iter_load),
        .step   (iter_step),
        .div    (iter_div),
        .a      (a),
        .b      (b),
        .last   (iter_last),
        .result (iter_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sum      <= '0;
            zout     <= 1'b1;
            dz       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_FIN: begin
                    state <= ST_IDLE;
                    if (start) begin
                        case (gin)
                            OP_MUL: begin
                                state <= ST_MUL;
                                busy  <= 1'b1;
                            end
                            OP_DIVU: begin
                                state    <= ST_DIV;
                                busy     <= 1'b1;
                                div_zero <= (b == '0);
                            end
                            default: begin
                                state <= ST_FIN;
                                done  <= 1'b1;
                                sum   <= quick_result;
                                zout  <= (quick_result == '0);
                                dz    <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (state == ST_DIV && div_zero) begin
                        state <= ST_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= '1;
                        zout  <= 1'b0;
                        dz    <= 1'b1;
                    end else if (iter_last) begin
                        state <= ST_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= iter_result;
                        zout  <= (iter_result == '0);
                        dz    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32, plus a WIDTH=8 instance for MUL overflow.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  gin;
    logic [31:0] a, b;
    logic [31:0] sum;
    logic        zout, dz, busy, done;

    logic        start8;
    logic [3:0]  gin8;
    logic [7:0]  a8, b8;
    logic [7:0]  sum8;
    logic        zout8, dz8, busy8, done8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .CNTW(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gin(gin), .a(a), .b(b),
        .sum(sum), .zout(zout), .dz(dz), .busy(busy), .done(done)
    );

    alu_seq #(.WIDTH(8), .CNTW(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .gin(gin8), .a(a8), .b(b8),
        .sum(sum8), .zout(zout8), .dz(dz8), .busy(busy8), .done(done8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; on return the bench sits in cycle 1 after start
    task automatic do_start(input logic [3:0] g, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        gin   = g;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    task automatic check_single(input string name, input logic [31:0] exp_sum, input logic exp_z);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== exp_sum || zout !== exp_z || dz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: done=%b busy=%b sum=%h zout=%b dz=%b, required done=1 busy=0 sum=%h zout=%b dz=0",
                     name, done, busy, sum, zout, dz, exp_sum, exp_z);
        end
    endtask

    // Runs an already-started op to completion, counting busy cycles; mid_cycle>0 injects an ignored start
    task automatic wait_done(input int mid_cycle, output int done_cyc, output int busy_cnt);
        done_cyc = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            if (c == mid_cycle) begin
                start = 1'b1;
                gin   = OP_ADD;
                a     = 32'd1;
                b     = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (sum !== 32'd0 || zout !== 1'b1 || dz !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: sum=%h zout=%b dz=%b busy=%b done=%b, required 0 1 0 0 0",
                     sum, zout, dz, busy, done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        do_start(OP_ADD, 32'hFFFF_FFFF, 32'd1);
        check_single("add_wrap", 32'd0, 1'b1);
        tick();
        checks++;
        if (done !== 1'b0 || sum !== 32'd0 || zout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_hold: done=%b sum=%h zout=%b, required done=0 sum=0 zout=1", done, sum, zout);
        end
        do_start(OP_SUB, 32'd5, 32'd7);
        check_single("sub", 32'hFFFF_FFFE, 1'b0);
        tick();
    endtask

    // Each op is started in the FIN cycle of the previous one
    task automatic test_back_to_back();
        do_start(OP_SLT, 32'h8000_0000, 32'd1);
        check_single("slt_neg", 32'd1, 1'b0);
        do_start(OP_SLTU, 32'h8000_0000, 32'd1);
        check_single("sltu", 32'd0, 1'b1);
        do_start(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
        check_single("slt_ovf", 32'd0, 1'b1);
        do_start(OP_AND, 32'hF0F0_1234, 32'h0FF0_00FF);
        check_single("and", 32'h00F0_0034, 1'b0);
        do_start(OP_OR, 32'hF0F0_1234, 32'h0FF0_00FF);
        check_single("or", 32'hFFF0_12FF, 1'b0);
        do_start(OP_NOR, 32'hF0F0_1234, 32'h0FF0_00FF);
        check_single("nor", 32'h000F_ED00, 1'b0);
        do_start(4'b1111, 32'h1234_5678, 32'h1);
        check_single("undef", 32'd0, 1'b1);
        tick();
    endtask

    task automatic test_mul();
        int dc, bc;
        do_start(OP_MUL, 32'd12345, 32'd6789);
        wait_done(5, dc, bc);
        checks++;
        if (dc != 33 || bc != 32 || busy !== 1'b0 || sum !== 32'd83810205 || zout !== 1'b0 || dz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul: done_cycle=%0d busy_cycles=%0d busy=%b sum=%0d zout=%b dz=%b, required 33 32 0 83810205 0 0",
                     dc, bc, busy, sum, zout, dz);
        end
        tick();
    endtask

    task automatic test_divu();
        int dc, bc;
        do_start(OP_DIVU, 32'd100, 32'd7);
        wait_done(0, dc, bc);
        checks++;
        if (dc != 33 || bc != 32 || sum !== 32'd14 || dz !== 1'b0 || zout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divu: done_cycle=%0d busy_cycles=%0d sum=%0d dz=%b zout=%b, required 33 32 14 0 0",
                     dc, bc, sum, dz, zout);
        end
        do_start(OP_DIVU, 32'd5, 32'd0);
        wait_done(0, dc, bc);
        checks++;
        if (dc != 2 || sum !== 32'hFFFF_FFFF || dz !== 1'b1 || zout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div_zero: done_cycle=%0d sum=%h dz=%b zout=%b, required 2 ffffffff 1 0",
                     dc, sum, dz, zout);
        end
        do_start(OP_ADD, 32'd10, 32'd20);
        check_single("dz_clear", 32'd30, 1'b0);
        tick();
    endtask

    task automatic test_reset_abort();
        int dc, bc;
        do_start(OP_DIVU, 32'd9, 32'd0);
        wait_done(0, dc, bc);
        do_start(OP_MUL, 32'd12345, 32'd6789);
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (sum !== 32'd0 || zout !== 1'b1 || dz !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_abort: sum=%h zout=%b dz=%b busy=%b done=%b, required 0 1 0 0 0",
                     sum, zout, dz, busy, done);
        end
        tick();
        tick();
        rst_n = 1'b1;
        wait_done(0, dc, bc);
        checks++;
        if (dc != 0 || bc != 0) begin
            errors++;
            $display("[TB] FAIL no_done_after_abort: done_cycle=%0d busy_cycles=%0d, required 0 0", dc, bc);
        end
        do_start(OP_ADD, 32'd3, 32'd4);
        check_single("add_after_reset", 32'd7, 1'b0);
        tick();
    endtask

    task automatic test_width8_mul();
        int dc;
        dc     = 0;
        start8 = 1'b1;
        gin8   = OP_MUL;
        a8     = 8'h10;
        b8     = 8'h10;
        tick();
        start8 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (done8 === 1'b1) begin
                dc = c;
                break;
            end
            tick();
        end
        checks++;
        if (dc != 9 || sum8 !== 8'h00 || zout8 !== 1'b1 || dz8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul8: done_cycle=%0d sum=%h zout=%b dz=%b, required 9 00 1 0", dc, sum8, zout8, dz8);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        gin    = 4'd0;
        a      = '0;
        b      = '0;
        start8 = 1'b0;
        gin8   = 4'd0;
        a8     = '0;
        b8     = '0;
        tick();
        tick();
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_divu();
        test_reset_abort();
        test_width8_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
